// File: rtl/csp_channel_pkg.sv
// Shared types for the single-token bundled-data channel: protocol selector and
// the sender/receiver FSM state encodings.
package csp_channel_pkg;

  typedef enum logic {
    P4PhaseBD = 1'b0,
    P2PhaseBD = 1'b1
  } protocol_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } s_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_WAIT = 2'd2
  } r_state_e;

endpackage

// File: rtl/csp_channel.sv
// One-token buffered handshake channel between a sender and a receiver,
// 4-phase or 2-phase bundled data, with an idle status output.
module csp_channel
  import csp_channel_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int PROTOCOL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_req,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ack,
  output logic             r_req,
  output logic [WIDTH-1:0] r_data,
  input  logic             r_ack,
  output logic             idle
);

  localparam bit TwoPhase = (PROTOCOL == int'(P2PhaseBD));

  s_state_e         s_state_q;
  r_state_e         r_state_q;
  logic             s_ack_q;
  logic             r_req_q;
  logic             full_q;
  logic             full_d;
  logic [WIDTH-1:0] data_q;
  logic             capture;
  logic             consume;

  // Capture only sees full_q from before the edge, so a token consumed on this
  // edge frees the slot for the next cycle, never the same one.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    capture = 1'b0;
    consume = 1'b0;
    if (TwoPhase) begin
      capture = (s_req != s_ack_q) && !full_q;
      consume = (r_state_q == R_REQ) && (r_ack == r_req_q);
    end else begin
      capture = (s_state_q == S_IDLE) && s_req && !full_q;
      consume = (r_state_q == R_REQ) && r_ack;
    end
  end

  assign full_d = capture | (full_q & ~consume);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the data register is cleared on reset because r_data must read 0 after reset.
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every process sees pre-edge values.
      full_q <= full_d;
      if (capture) data_q <= s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_state_q <= S_IDLE;
      s_ack_q   <= 1'b0;
    end else if (TwoPhase) begin
      if (capture) s_ack_q <= s_req;
    end else begin
      case (s_state_q)
        S_IDLE: if (capture) begin
          s_state_q <= S_ACK;
          s_ack_q   <= 1'b1;
        end
        S_ACK: if (!s_req) begin
          s_state_q <= S_IDLE;
          s_ack_q   <= 1'b0;
        end
        default: s_state_q <= S_IDLE;
      endcase
    end
  end

  // In 2-phase mode R_REQ means "r_req toggled, waiting for r_ack to match it".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      r_req_q   <= 1'b0;
    end else begin
      case (r_state_q)
        R_IDLE: if (full_q && (!TwoPhase || (r_req_q == r_ack))) begin
          r_state_q <= R_REQ;
          r_req_q   <= TwoPhase ? ~r_req_q : 1'b1;
        end
        R_REQ: if (consume) begin
          r_state_q <= TwoPhase ? R_IDLE : R_WAIT;
          if (!TwoPhase) r_req_q <= 1'b0;
        end
        R_WAIT: if (!r_ack) r_state_q <= R_IDLE;
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign s_ack  = s_ack_q;
  assign r_req  = r_req_q;
  assign r_data = data_q;
  assign idle   = TwoPhase ? (~full_q & (s_req == s_ack_q) & (r_req_q == r_ack))
                           : (~full_q & ~s_ack_q & ~r_req_q & ~r_ack);

endmodule

// File: tb/tb_csp_channel.sv
// Bench for csp_channel: a 64-bit 4-phase instance and a 13-bit 2-phase instance
// share clock and reset.
module tb_csp_channel;
  import csp_channel_pkg::*;

  localparam int W  = 64;
  localparam int W2 = 13;
  localparam int NTOK = 21;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          s_req, r_ack, s_ack, r_req, idle;
  logic [W-1:0]  s_data, r_data;
  logic          s_req2, r_ack2, s_ack2, r_req2, idle2;
  logic [W2-1:0] s_data2, r_data2;

  csp_channel #(.WIDTH(W), .PROTOCOL(int'(P4PhaseBD))) u_dut4 (
    .clk(clk), .rst_n(rst_n), .s_req(s_req), .s_data(s_data), .s_ack(s_ack),
    .r_req(r_req), .r_data(r_data), .r_ack(r_ack), .idle(idle)
  );

  csp_channel #(.WIDTH(W2), .PROTOCOL(int'(P2PhaseBD))) u_dut2 (
    .clk(clk), .rst_n(rst_n), .s_req(s_req2), .s_data(s_data2), .s_ack(s_ack2),
    .r_req(r_req2), .r_data(r_data2), .r_ack(r_ack2), .idle(idle2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic         s_req;
    logic [W-1:0] s_data;
    logic         r_ack;
    logic         s_ack;
    logic         r_req;
    logic [W-1:0] r_data;
    logic         idle;
  } vec_t;

  vec_t vecs [15];

  // Stream scoreboard: tokens the channel has accepted but not yet delivered.
  logic [W-1:0] sb [$];
  int sent, got, sdelay, rdelay, cyc;
  logic prev_sack, prev_rreq;
  logic exp_rreq2;
  logic [W2-1:0] toks2 [4];

  initial begin
    logic [W-1:0] t0, t1, a5;
    t0 = 64'h0011_1111_1111;
    t1 = 64'hDEAD_BEEF_0123_4567;
    a5 = 64'hA5;
    //            s_req s_data r_ack | s_ack r_req r_data idle
    vecs[0]  = '{1'b1, t0, 1'b0, 1'b1, 1'b0, t0, 1'b0};
    vecs[1]  = '{1'b1, t0, 1'b0, 1'b1, 1'b1, t0, 1'b0};
    vecs[2]  = '{1'b0, t0, 1'b0, 1'b0, 1'b1, t0, 1'b0};
    vecs[3]  = '{1'b0, t0, 1'b1, 1'b0, 1'b0, t0, 1'b0};
    vecs[4]  = '{1'b0, t0, 1'b0, 1'b0, 1'b0, t0, 1'b1};
    vecs[5]  = '{1'b1, t1, 1'b0, 1'b1, 1'b0, t1, 1'b0};
    vecs[6]  = '{1'b0, t1, 1'b0, 1'b0, 1'b1, t1, 1'b0};
    vecs[7]  = '{1'b1, a5, 1'b0, 1'b0, 1'b1, t1, 1'b0};
    vecs[8]  = '{1'b1, a5, 1'b0, 1'b0, 1'b1, t1, 1'b0};
    vecs[9]  = '{1'b1, a5, 1'b1, 1'b0, 1'b0, t1, 1'b0};
    vecs[10] = '{1'b1, a5, 1'b1, 1'b1, 1'b0, a5, 1'b0};
    vecs[11] = '{1'b0, a5, 1'b0, 1'b0, 1'b0, a5, 1'b0};
    vecs[12] = '{1'b0, a5, 1'b0, 1'b0, 1'b1, a5, 1'b0};
    vecs[13] = '{1'b0, a5, 1'b1, 1'b0, 1'b0, a5, 1'b0};
    vecs[14] = '{1'b0, a5, 1'b0, 1'b0, 1'b0, a5, 1'b1};

    toks2[0] = 13'h1ABC;
    toks2[1] = 13'h0555;
    toks2[2] = 13'h1FFF;
    toks2[3] = 13'h0001;

    rst_n = 1'b0;
    s_req = 1'b0; s_data = '0; r_ack = 1'b0;
    s_req2 = 1'b0; s_data2 = '0; r_ack2 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("reset s_ack", s_ack, 1'b0);
    check("reset r_req", r_req, 1'b0);
    check("reset r_data", r_data, '0);
    check("reset idle", idle, 1'b1);
    check("reset 2p s_ack", s_ack2, 1'b0);
    check("reset 2p r_req", r_req2, 1'b0);
    check("reset 2p idle", idle2, 1'b1);

    // 4-phase single transfer followed by the back-pressure sequence.
    for (int i = 0; i < 15; i++) begin
      s_req  = vecs[i].s_req;
      s_data = vecs[i].s_data;
      r_ack  = vecs[i].r_ack;
      step();
      check($sformatf("vec%0d s_ack", i), s_ack, vecs[i].s_ack);
      check($sformatf("vec%0d r_req", i), r_req, vecs[i].r_req);
      check($sformatf("vec%0d r_data", i), r_data, vecs[i].r_data);
      check($sformatf("vec%0d idle", i), idle, vecs[i].idle);
    end

    // 2-phase transfers: each token is one s_req toggle and one r_ack toggle.
    exp_rreq2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      s_data2 = toks2[k];
      s_req2  = ~s_req2;
      step();
      check($sformatf("2p tok%0d s_ack", k), s_ack2, s_req2);
      check($sformatf("2p tok%0d r_data", k), r_data2, toks2[k]);
      check($sformatf("2p tok%0d busy", k), idle2, 1'b0);
      step();
      exp_rreq2 = ~exp_rreq2;
      check($sformatf("2p tok%0d r_req", k), r_req2, exp_rreq2);
      r_ack2 = ~r_ack2;
      step();
      check($sformatf("2p tok%0d idle", k), idle2, 1'b1);
      check($sformatf("2p tok%0d r_req held", k), r_req2, exp_rreq2);
      check($sformatf("2p tok%0d s_ack held", k), s_ack2, s_req2);
    end

    // Randomized ordered stream of tokens 0..NTOK-1 on the 4-phase channel.
    sent = 0; got = 0; cyc = 0;
    sdelay = $urandom_range(0, 3);
    rdelay = $urandom_range(0, 3);
    prev_sack = s_ack;
    prev_rreq = r_req;
    while (got < NTOK && cyc < 2000) begin
      if (prev_rreq && !r_req) begin
        check("stream pop nonempty", 64'(sb.size()), 64'd1);
        if (sb.size() > 0) begin
          check($sformatf("stream order %0d", got), sb.pop_front(), 64'(got));
          got++;
        end
      end
      if (!prev_sack && s_ack) begin
        check("stream single token", 64'(sb.size()), 64'd0);
        sb.push_back(s_data);
      end
      if (r_req) begin
        if (sb.size() > 0) check("stream r_data stable", r_data, sb[0]);
        else check("stream r_req with no token", 64'(sb.size()), 64'd1);
      end

      if (!s_req && !s_ack && sent < NTOK) begin
        if (sdelay == 0) begin
          s_req  = 1'b1;
          s_data = W'(sent);
          sdelay = $urandom_range(0, 3);
        end else sdelay--;
      end else if (s_req && s_ack) begin
        s_req = 1'b0;
        sent++;
      end

      if (r_req && !r_ack) begin
        if (rdelay == 0) begin
          r_ack  = 1'b1;
          rdelay = $urandom_range(0, 3);
        end else rdelay--;
      end else if (!r_req && r_ack) begin
        r_ack = 1'b0;
      end

      prev_sack = s_ack;
      prev_rreq = r_req;
      step();
      cyc++;
    end
    check("stream received count", 64'(got), 64'(NTOK));
    r_ack = 1'b0;
    s_req = 1'b0;
    step();
    step();
    check("stream drained idle", idle, 1'b1);

    // Asynchronous reset while a token is waiting at the receiver.
    s_req  = 1'b1;
    s_data = 64'hCAFE_F00D;
    step();
    step();
    check("pre-reset r_req", r_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset r_req", r_req, 1'b0);
    check("async reset s_ack", s_ack, 1'b0);
    check("async reset r_data", r_data, '0);
    check("async reset idle", idle, 1'b1);
    s_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    s_req  = 1'b1;
    s_data = 64'h1234_5678_9ABC_DEF0;
    step();
    check("post-reset s_ack", s_ack, 1'b1);
    check("post-reset r_data", r_data, 64'h1234_5678_9ABC_DEF0);
    s_req = 1'b0;
    step();
    check("post-reset r_req", r_req, 1'b1);
    r_ack = 1'b1;
    step();
    check("post-reset consume", r_req, 1'b0);
    r_ack = 1'b0;
    step();
    check("post-reset idle", idle, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
